// File: rtl/sd_arb_pkg.sv
// Shared types and default widths for the SD register RAM arbiter.
package sd_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 7;
  localparam int unsigned ARB_DATA_W = 8;

  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_SD  = 1'b1
  } req_id_t;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } ret_slot_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; ptr names the requester that wins a tie.
module rr_pick2
  import sd_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    ptr,
  output logic       win_valid,
  output req_id_t    win_id
);

  always_comb begin
    win_valid = |eligible;
    win_id    = REQ_SPI;
    case (eligible)
      2'b01:   win_id = REQ_SPI;
      2'b10:   win_id = REQ_SD;
      2'b11:   win_id = ptr;
      default: win_id = REQ_SPI;
    endcase
  end

endmodule

// File: rtl/sd_reg_arbiter.sv
// Round-robin arbiter sharing the single-port SD register RAM between the SPI link
// and the SD engine, with a tagged 2-stage read-return pipeline.
module sd_reg_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  req_id_t           ptr_q, ptr_d;
  ret_slot_t         slot_a_q, slot_a_d, slot_b_q, slot_b_d;

  logic              win_valid;
  req_id_t           win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        eligible;

  // A requester sitting on its own grant pulse gets one cycle to drop or change req.
  assign eligible = {req1 & ~gnt1_q, req0 & ~gnt0_q};

  rr_pick2 u_rr_pick2 (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  always_comb begin
    win_we    = (win_id == REQ_SD) ? we1    : we0;
    win_addr  = (win_id == REQ_SD) ? addr1  : addr0;
    win_wdata = (win_id == REQ_SD) ? wdata1 : wdata0;
  end

  always_comb begin
    gnt0_d      = win_valid & (win_id == REQ_SPI);
    gnt1_d      = win_valid & (win_id == REQ_SD);
    ptr_d       = ptr_q;
    if (win_valid) begin
      ptr_d = (win_id == REQ_SPI) ? REQ_SD : REQ_SPI;
    end
    mem_en_d    = win_valid;
    mem_we_d    = win_valid & win_we;
    mem_addr_d  = win_valid ? win_addr  : mem_addr_q;
    mem_wdata_d = win_valid ? win_wdata : mem_wdata_q;

    slot_a_d.valid = win_valid & ~win_we;
    slot_a_d.owner = win_id;
    slot_b_d       = slot_a_q;

    // RAM data is valid while stage B holds a read.
    rvalid0_d = slot_b_q.valid & (slot_b_q.owner == REQ_SPI);
    rvalid1_d = slot_b_q.valid & (slot_b_q.owner == REQ_SD);
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= REQ_SPI;
      slot_a_q    <= '0;
      slot_b_q    <= '0;
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ptr_q       <= ptr_d;
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = slot_a_q.valid | slot_b_q.valid;

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Self-checking bench for sd_reg_arbiter: directed vector table, hand sequences for
// contention and reset, then randomized traffic against a transaction-level model.
module tb_sd_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0, we0, req1, we1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_we, busy;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  always #5 clk = ~clk;

  sd_reg_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rdata0    (rdata0),
    .rvalid0   (rvalid0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rdata1    (rdata1),
    .rvalid1   (rvalid1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Register RAM: 128 x 8, synchronous read with one cycle of latency.
  logic [7:0] ram [128];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Transaction-level reference model.
  typedef struct {
    int         due;
    int         owner;
    logic [7:0] data;
  } ret_t;

  logic [7:0] m_mem [128];
  ret_t       m_q[$];
  int         cyc, last_win;
  bit         m_gnt0, m_gnt1, m_en, m_we, m_rv0, m_rv1;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rd0, m_rd1;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt0 = 0; m_gnt1 = 0; m_en = 0; m_we = 0; m_rv0 = 0; m_rv1 = 0;
    m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    last_win = 1;  // so requester 0 takes the first tie
    m_q.delete();
  endtask

  // Apply the arbitration rules to the inputs present at this clock edge.
  task automatic model_edge();
    bit         e0, e1, w_we;
    int         win;
    logic [6:0] a;
    logic [7:0] d;
    ret_t       r;
    e0  = req0 && !m_gnt0;
    e1  = req1 && !m_gnt1;
    win = -1;
    if (e0 && e1)  win = 1 - last_win;
    else if (e0)   win = 0;
    else if (e1)   win = 1;
    cyc++;
    m_rv0 = 0;
    m_rv1 = 0;
    while (m_q.size() > 0 && m_q[0].due == cyc) begin
      r = m_q.pop_front();
      if (r.owner == 0) begin m_rv0 = 1; m_rd0 = r.data; end
      else              begin m_rv1 = 1; m_rd1 = r.data; end
    end
    m_gnt0 = (win == 0);
    m_gnt1 = (win == 1);
    m_en   = (win >= 0);
    m_we   = 0;
    if (win >= 0) begin
      w_we     = (win == 1) ? we1 : we0;
      a        = (win == 1) ? addr1 : addr0;
      d        = (win == 1) ? wdata1 : wdata0;
      m_we     = w_we;
      m_addr   = a;
      m_wdata  = d;
      last_win = win;
      if (w_we) m_mem[a] = d;
      else      m_q.push_back('{cyc + 2, win, m_mem[a]});
    end
  endtask

  task automatic compare_all();
    chk("gnt0", gnt0, m_gnt0);
    chk("gnt1", gnt1, m_gnt1);
    chk("mem_en", mem_en, m_en);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rvalid0", rvalid0, m_rv0);
    chk("rvalid1", rvalid1, m_rv1);
    chk("rdata0", rdata0, m_rd0);
    chk("rdata1", rdata1, m_rd1);
    chk("busy", busy, m_q.size() != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit r0; bit w0; logic [6:0] a0; logic [7:0] d0;
    bit r1; bit w1; logic [6:0] a1; logic [7:0] d1;
    bit g0; bit g1; bit en; bit we; logic [6:0] ma;
    bit v0; bit v1; logic [7:0] rd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    idle_inputs();
    for (int i = 0; i < 128; i++) begin
      ram[i]   = 8'($urandom);
      m_mem[i] = ram[i];
    end
    ram[7'h05] = 8'hA5; m_mem[7'h05] = 8'hA5;
    ram[7'h20] = 8'h77; m_mem[7'h20] = 8'h77;
    ram[7'h21] = 8'h88; m_mem[7'h21] = 8'h88;
    ram[7'h30] = 8'h11; m_mem[7'h30] = 8'h11;
    cyc = 0;

    //        r0 w0 a0     d0     r1 w1 a1     d1     g0 g1 en we ma     v0 v1 rd
    tbl[0]  = '{1, 0, 7'h05, 8'h00, 0, 0, 7'h00, 8'h00, 1, 0, 1, 0, 7'h05, 0, 0, 8'h00};
    tbl[1]  = '{0, 0, 7'h05, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h05, 0, 0, 8'h00};
    tbl[2]  = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h05, 1, 0, 8'hA5};
    tbl[3]  = '{0, 0, 7'h00, 8'h00, 1, 1, 7'h10, 8'h3C, 0, 1, 1, 1, 7'h10, 0, 0, 8'h00};
    tbl[4]  = '{0, 0, 7'h00, 8'h00, 1, 0, 7'h10, 8'h00, 0, 0, 0, 0, 7'h10, 0, 0, 8'h00};
    tbl[5]  = '{0, 0, 7'h00, 8'h00, 1, 0, 7'h10, 8'h00, 0, 1, 1, 0, 7'h10, 0, 0, 8'h00};
    tbl[6]  = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h10, 0, 0, 8'h00};
    tbl[7]  = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h10, 0, 1, 8'h3C};
    tbl[8]  = '{1, 0, 7'h20, 8'h00, 1, 0, 7'h21, 8'h00, 1, 0, 1, 0, 7'h20, 0, 0, 8'h00};
    tbl[9]  = '{1, 0, 7'h20, 8'h00, 1, 0, 7'h21, 8'h00, 0, 1, 1, 0, 7'h21, 0, 0, 8'h00};
    tbl[10] = '{1, 0, 7'h20, 8'h00, 1, 0, 7'h21, 8'h00, 1, 0, 1, 0, 7'h20, 1, 0, 8'h77};
    tbl[11] = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h20, 0, 1, 8'h88};
    tbl[12] = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h20, 1, 0, 8'h77};
    tbl[13] = '{1, 0, 7'h40, 8'h00, 1, 0, 7'h30, 8'h00, 0, 1, 1, 0, 7'h30, 0, 0, 8'h00};
    tbl[14] = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h30, 0, 0, 8'h00};
    tbl[15] = '{0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0, 7'h30, 0, 1, 8'h11};

    #2;
    do_reset(2);

    // Directed vectors: single read, write-then-read, tie memory, abandoned request.
    for (int i = 0; i < 16; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      step();
      chk($sformatf("vec%0d gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("vec%0d gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("vec%0d mem_en", i), mem_en, tbl[i].en);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].ma);
      chk($sformatf("vec%0d rvalid0", i), rvalid0, tbl[i].v0);
      chk($sformatf("vec%0d rvalid1", i), rvalid1, tbl[i].v1);
      if (tbl[i].v0) chk($sformatf("vec%0d rdata0", i), rdata0, tbl[i].rd);
      if (tbl[i].v1) chk($sformatf("vec%0d rdata1", i), rdata1, tbl[i].rd);
    end
    idle_inputs();
    step();

    // Contention straight after reset: grants alternate starting with requester 0.
    do_reset(1);
    req0 = 1; addr0 = 7'h01; req1 = 1; addr1 = 7'h02;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("cont%0d gnt0", i), gnt0, (i % 2) == 0);
      chk($sformatf("cont%0d gnt1", i), gnt1, (i % 2) == 1);
      chk($sformatf("cont%0d mem_en", i), mem_en, 1'b1);
    end
    idle_inputs();
    repeat (3) step();

    // Reset mid-read: in-flight read must never return, pointer back to requester 0.
    req1 = 1; addr1 = 7'h03;
    step();
    req1 = 0; req0 = 1; addr0 = 7'h05;
    step();
    chk("midrst gnt0", gnt0, 1'b1);
    req0 = 0;
    step();
    do_reset(1);
    chk("midrst busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("midrst rvalid0 %0d", i), rvalid0, 1'b0);
    end
    req0 = 1; req1 = 1;
    step();
    chk("midrst tie gnt0", gnt0, 1'b1);
    idle_inputs();
    repeat (3) step();

    // Randomized traffic on a small address window to provoke RAW hazards.
    for (int i = 0; i < 600; i++) begin
      req0   = ($urandom_range(0, 3) != 0);
      we0    = 1'($urandom_range(0, 1));
      addr0  = 7'($urandom_range(0, 7));
      wdata0 = 8'($urandom);
      req1   = ($urandom_range(0, 3) != 0);
      we1    = 1'($urandom_range(0, 1));
      addr1  = 7'($urandom_range(0, 7));
      wdata1 = 8'($urandom);
      step();
      if (i == 300) do_reset(1);
    end
    idle_inputs();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_reg_arbiter.md
Name: sd_reg_arbiter

Overview:
- Shares the single-port SD register RAM (128 x 8, synchronous read, 1-cycle latency) between two requesters.
- Requester 0 is the SPI link (host register access). Requester 1 is the SD card engine.
- Serialises accesses with round-robin arbitration and returns read data with a tagged valid to the requester that issued the read.
- Sits between the SPI link state machine, the SD engine and the register RAM.

Parameters:
ADDR_W, 7, register address width (128 registers)
DATA_W, 8, register data width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 (SPI) access request; level, held until gnt0
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  one-cycle pulse: requester 0 request consumed
rdata0  out  DATA_W  read data to requester 0
rvalid0  out  1  one-cycle pulse: rdata0 valid
req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1  same as above, for requester 1 (SD engine)
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable (only meaningful with mem_en)
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0
busy  out  1  high while any read is in the return pipeline

Behaviour:
- Reset (rst_n low, asynchronous): gnt*, rvalid*, mem_en, mem_we and busy are 0; mem_addr, mem_wdata and rdata* are 0; RR pointer is 0 (requester 0 wins the first tie); return pipeline is cleared.
- Eligibility at each clock edge: eligible_i = req_i & ~gnt_i. A requester is never granted on the edge where its own gnt is high, which gives it one cycle to drop or change req.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible: the one not granted most recently wins (RR pointer).
  - The pointer updates only on a grant and then points away from the winner.
- Issue (same edge as the grant, all registered):
  - gnt_w <= 1.
  - mem_en <= 1.
  - mem_we <= we_w; mem_addr <= addr_w; mem_wdata <= wdata_w.
  - With no winner: mem_en <= 0 and mem_we <= 0; addr and data hold their values.
- Read return pipeline, 2 stages, each holding {valid, owner}:
  - Stage A is loaded at issue with valid = ~we_w.
  - Stage B <= stage A on the next edge. mem_rdata is sampled while stage B is valid: rdata_owner <= mem_rdata and rvalid_owner <= 1 for one cycle.
  - rdata of the non-owner holds its value.
  - Read latency: rvalid arrives 2 cycles after gnt. Writes produce no rvalid.
- Throughput:
  - One RAM access per cycle when requesters alternate.
  - A single requester gets at most one access every 2 cycles.
- busy = stage A valid | stage B valid.
- Ordering: accesses hit the RAM in grant order. A read granted after a write to the same address returns the new data.
- Simultaneous events: a new grant and a read return in the same cycle are independent; both proceed.
- A requester may drop req at any time without being granted; this is not an error and no access occurs.
- Changing addr, we or wdata while req is high and ungranted is allowed; the values sampled on the grant edge are used.
- Reset mid-operation clears in-flight reads; no rvalid is emitted for them.

Decomposition:
- Package sd_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - Typedef req_id_t (enum REQ_SPI = 0, REQ_SD = 1).
  - Packed struct ret_slot_t {valid, owner}.
- Sub-module rr_pick2: a combinational 2-way round-robin picker (eligible[1:0], ptr -> win_valid, win_id), instantiated once.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x05, with RAM[5]=0xA5 -> gnt0 pulses at T+1, mem_en=1, mem_addr=0x05, rvalid0=1 and rdata0=0xA5 at T+3; rvalid1 stays 0.
- Write then read: req1 write addr 0x10, data 0x3C; after gnt1, req1 read 0x10 -> mem_we=1 on the first access; rvalid1 with rdata1=0x3C; no rvalid for the write.
- Contention: req0 and req1 both held for 8 cycles after reset -> grants alternate 0,1,0,1 with a grant every cycle; no requester is granted on consecutive cycles.
- Tie-break memory: grant to 1 alone, then both request -> requester 0 wins next.
- Reset mid-read: assert rst_n low one cycle after gnt0 of a read -> all outputs 0 immediately; no rvalid0 after release; next tie goes to requester 0.
- Abandoned request: req0 high one cycle while requester 1 is granted, then dropped -> no gnt0, no mem_en for requester 0's address.
